wb4_sync_fifo_1_to_1: RTL and testbench

WB4_SYNC_FIFO_1_TO_1 -- requirements
Module: wb4_sync_fifo_1_to_1

---
 rtl/wb4_sync_fifo_1_to_1_pkg.sv | 23 ++
 rtl/wb4_fifo_mem.sv | 58 +++++
 rtl/wb4_sync_fifo_1_to_1.sv | 91 +++++++++
 tb/tb_wb4_sync_fifo_1_to_1.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb4_sync_fifo_1_to_1_pkg.sv
// Shared helpers for the wb4 FIFO family: the clog2 used to size pointers
// and the fill classification derived from the registered pointers.
package wb4_sync_fifo_1_to_1_pkg;

    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_PARTIAL = 2'd1,
        FILL_FULL    = 2'd2
    } fill_state_e;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wb4_fifo_mem.sv
// Simple dual-port storage: one write port and one registered read port whose
// output only moves on a read enable, so the last read word is held.
module wb4_fifo_mem #(
    parameter int P_DATA_W   = 8,
    parameter int P_ADDR_W   = 7,
    parameter int P_USE_BRAM = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [P_ADDR_W-1:0] wr_addr,
    input  logic [P_DATA_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [P_ADDR_W-1:0] rd_addr,
    output logic [P_DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << P_ADDR_W;

    // Both styles share the same registered-output timing; only the array mapping differs.
    if (P_USE_BRAM != 0) begin : g_bram
        (* ram_style = "block" *) logic [P_DATA_W-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data <= '0;
            end else if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end else begin : g_lut
        (* ram_style = "distributed" *) logic [P_DATA_W-1:0] mem [DEPTH];
        logic [P_DATA_W-1:0] rd_word;

        assign rd_word = mem[rd_addr];

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data <= '0;
            end else if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: rtl/wb4_sync_fifo_1_to_1.sv
// Single-clock FIFO with a pipelined Wishbone slave port on each side.
// Status flags come only from the registered pointers, never from inputs.
module wb4_sync_fifo_1_to_1
    import wb4_sync_fifo_1_to_1_pkg::*;
#(
    parameter int P_DATA_MSB = 7,
    parameter int P_DEPTH    = 128,
    parameter int P_USE_BRAM = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wb4_in_scyc,
    input  logic              i_wb4_in_sstb,
    output logic              o_wb4_in_sack,
    input  logic [P_DATA_MSB:0] i_wb4_in_sdata,
    output logic              o_wb4_in_stgd,
    output logic              o_wb4_in_sstall,
    input  logic              i_wb4_out_scyc,
    input  logic              i_wb4_out_sstb,
    output logic              o_wb4_out_sack,
    output logic [P_DATA_MSB:0] o_wb4_out_sdata,
    output logic              o_wb4_out_stgd,
    output logic              o_wb4_out_sstall
);

    localparam int ADDR_W = clog2(P_DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    fill_state_e     fill;
    logic            wr_accept;
    logic            rd_accept;
    logic            in_ack;
    logic            out_ack;

    // Equal pointers mean empty; equal addresses with differing wrap bits mean full.
    always_comb begin
        fill = FILL_PARTIAL;
        if (wr_ptr == rd_ptr) begin
            fill = FILL_EMPTY;
        end else if (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) begin
            fill = FILL_FULL;
        end
    end

    assign wr_accept = i_wb4_in_scyc  & i_wb4_in_sstb  & (fill != FILL_FULL);
    assign rd_accept = i_wb4_out_scyc & i_wb4_out_sstb & (fill != FILL_EMPTY);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            in_ack  <= 1'b0;
            out_ack <= 1'b0;
        end else begin
            in_ack  <= wr_accept;
            out_ack <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Strobes landing in a reset cycle must not touch storage or the read register.
    wb4_fifo_mem #(
        .P_DATA_W   (P_DATA_MSB + 1),
        .P_ADDR_W   (ADDR_W),
        .P_USE_BRAM (P_USE_BRAM)
    ) u_mem (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (wr_accept & ~i_rst),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (i_wb4_in_sdata),
        .rd_en   (rd_accept & ~i_rst),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (o_wb4_out_sdata)
    );

    assign o_wb4_in_sack    = in_ack;
    assign o_wb4_out_sack   = out_ack;
    assign o_wb4_in_stgd    = (fill == FILL_EMPTY);
    assign o_wb4_in_sstall  = (fill == FILL_FULL);
    assign o_wb4_out_stgd   = (fill == FILL_FULL);
    assign o_wb4_out_sstall = (fill == FILL_EMPTY);

endmodule

// File: tb/tb_wb4_sync_fifo_1_to_1.sv
// Scoreboard bench for wb4_sync_fifo_1_to_1: a queue-based occupancy model
// predicts acks, flags and read data; a negedge monitor compares the DUT.
module tb_wb4_sync_fifo_1_to_1;

    localparam int DEPTH      = 128;
    localparam int STREAM_LEN = 300;
    localparam int STREAM_MAX = 8000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_scyc = 1'b0;
    logic       in_sstb = 1'b0;
    logic [7:0] in_sdata = 8'h00;
    logic       out_scyc = 1'b0;
    logic       out_sstb = 1'b0;
    logic       in_sack;
    logic       in_stgd;
    logic       in_sstall;
    logic       out_sack;
    logic [7:0] out_sdata;
    logic       out_stgd;
    logic       out_sstall;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] exp_sdata   = 8'h00;
    bit         exp_in_ack  = 1'b0;
    bit         exp_out_ack = 1'b0;
    bit         mon_en      = 1'b0;
    int         in_ack_count  = 0;
    int         out_ack_count = 0;
    int         write_count   = 0;

    wb4_sync_fifo_1_to_1 #(
        .P_DATA_MSB (7),
        .P_DEPTH    (DEPTH),
        .P_USE_BRAM (1)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_wb4_in_scyc    (in_scyc),
        .i_wb4_in_sstb    (in_sstb),
        .o_wb4_in_sack    (in_sack),
        .i_wb4_in_sdata   (in_sdata),
        .o_wb4_in_stgd    (in_stgd),
        .o_wb4_in_sstall  (in_sstall),
        .i_wb4_out_scyc   (out_scyc),
        .i_wb4_out_sstb   (out_sstb),
        .o_wb4_out_sack   (out_sack),
        .o_wb4_out_sdata  (out_sdata),
        .o_wb4_out_stgd   (out_stgd),
        .o_wb4_out_sstall (out_sstall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance the reference model across the edge.
    task automatic applyStimulus(input bit rst_v, input bit wcyc, input bit wstb, input logic [7:0] wdata,
                                 input bit rcyc, input bit rstb);
        bit full_m;
        bit empty_m;
        bit wacc;
        bit racc;
        rst      = rst_v;
        in_scyc  = wcyc;
        in_sstb  = wstb;
        in_sdata = wdata;
        out_scyc = rcyc;
        out_sstb = rstb;
        @(posedge clk);
        if (rst_v) begin
            model_q.delete();
            exp_rd_q.delete();
            exp_in_ack  = 1'b0;
            exp_out_ack = 1'b0;
            exp_sdata   = 8'h00;
        end else begin
            full_m  = (model_q.size() == DEPTH);
            empty_m = (model_q.size() == 0);
            wacc    = wcyc && wstb && !full_m;
            racc    = rcyc && rstb && !empty_m;
            if (racc) begin
                exp_rd_q.push_back(model_q.pop_front());
            end
            if (wacc) begin
                model_q.push_back(wdata);
                write_count++;
            end
            exp_in_ack  = wacc;
            exp_out_ack = racc;
        end
        mon_en = 1'b1;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: compare handshakes and flags every cycle, pop the scoreboard on each read ack.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("in_sack", {31'd0, in_sack}, {31'd0, exp_in_ack});
            checkOutput("out_sack", {31'd0, out_sack}, {31'd0, exp_out_ack});
            if (in_sack === 1'b1) begin
                in_ack_count++;
            end
            if (out_sack === 1'b1) begin
                out_ack_count++;
                checkOutput("sb_pending", {31'd0, exp_rd_q.size() != 0}, 32'd1);
                if (exp_rd_q.size() != 0) begin
                    exp_sdata = exp_rd_q.pop_front();
                end
            end
            checkOutput("out_sdata", {24'd0, out_sdata}, {24'd0, exp_sdata});
            checkOutput("in_stgd", {31'd0, in_stgd}, {31'd0, model_q.size() == 0});
            checkOutput("out_sstall", {31'd0, out_sstall}, {31'd0, model_q.size() == 0});
            checkOutput("in_sstall", {31'd0, in_sstall}, {31'd0, model_q.size() == DEPTH});
            checkOutput("out_stgd", {31'd0, out_stgd}, {31'd0, model_q.size() == DEPTH});
        end
    end

    initial begin
        int base_in;
        int base_out;
        int base_wr;
        int cyc;
        bit wc;
        bit ws;
        bit rc;
        bit rs;

        // Reset then idle: empty flags up, full flags down, no acks.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("reset_empty", {31'd0, in_stgd}, 32'd1);

        // Single write of 0xA5 with the read strobe held throughout.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        end
        idleCycle();
        checkOutput("a5_hold", {24'd0, out_sdata}, 32'h0000_00A5);

        // Fill to capacity, then one extra strobe that must be stalled.
        base_in = in_ack_count;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        idleCycle();
        checkOutput("burst_acks", in_ack_count - base_in, DEPTH);
        checkOutput("full_in_sstall", {31'd0, in_sstall}, 32'd1);
        checkOutput("full_out_stgd", {31'd0, out_stgd}, 32'd1);

        // From full: simultaneous read and write, then retry the write.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        idleCycle();
        checkOutput("from_full_data", {24'd0, out_sdata}, 32'h0000_0000);

        // Drain everything that is left.
        cyc = 0;
        while (model_q.size() != 0 && cyc < 1000) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            cyc++;
        end
        idleCycle();
        checkOutput("drain_bound", {31'd0, cyc < 1000}, 32'd1);

        // Random concurrent traffic with cycle drops across several pointer wraps.
        base_wr  = write_count;
        base_out = out_ack_count;
        cyc      = 0;
        while (((write_count - base_wr) < STREAM_LEN || model_q.size() != 0) && cyc < STREAM_MAX) begin
            wc = ($urandom_range(0, 7) != 0);
            ws = ($urandom_range(0, 3) != 0) && ((write_count - base_wr) < STREAM_LEN);
            rc = ($urandom_range(0, 7) != 0);
            rs = ($urandom_range(0, 2) != 0);
            applyStimulus(1'b0, wc, ws, 8'($urandom), rc, rs);
            cyc++;
        end
        idleCycle();
        checkOutput("stream_bound", {31'd0, cyc < STREAM_MAX}, 32'd1);
        checkOutput("stream_reads", out_ack_count - base_out, STREAM_LEN);

        // Reset with five entries stored and strobes active in the reset cycle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        end
        checkOutput("post_reset_stall", {31'd0, out_sstall}, 32'd1);
        idleCycle();

        checkOutput("sb_drained", exp_rd_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
